// File: rtl/fpnew_divsqrt_result_fifo.sv
// rtl/fpnew_divsqrt_result_fifo.sv - in-order result buffer between div/sqrt unit and output arbiter
//
// Purpose: lets the iterative div/sqrt unit hand off a finished result and
// start its next operation even while the output arbiter is back-pressuring.
// Each entry carries result, status flags, NaN-box extension bit, tag and aux.
//
// Ports:
//   clk_i, rst_ni              clock, synchronous active-low reset
//   result_i .. aux_i          entry payload from the div/sqrt stage
//   in_valid_i / in_ready_o    upstream handshake (in_ready_o = not full)
//   flush_i                    synchronous clear of all entries
//   result_o .. aux_o          head entry payload, zero when empty
//   out_valid_o / out_ready_i  downstream handshake (out_valid_o = not empty)
//   count_o                    number of occupied entries (0..Depth)
//   busy_o                     any entry held
module fpnew_divsqrt_result_fifo #(
    parameter int unsigned Width   = 64,
    parameter int unsigned Depth   = 4,
    parameter type         TagType = logic,
    parameter type         AuxType = logic
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [Width-1:0]           result_i,
    input  logic [4:0]                 status_i,
    input  logic                       extension_bit_i,
    input  TagType                     tag_i,
    input  AuxType                     aux_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic                       flush_i,
    output logic [Width-1:0]           result_o,
    output logic [4:0]                 status_o,
    output logic                       extension_bit_o,
    output TagType                     tag_o,
    output AuxType                     aux_o,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [$clog2(Depth+1)-1:0] count_o,
    output logic                       busy_o
);

    localparam int unsigned IdxW = $clog2(Depth);
    localparam int unsigned PtrW = IdxW + 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    // Entry storage; deliberately not reset, the pointers alone define validity.
    logic [Width-1:0] result_mem [Depth];
    logic [4:0]       status_mem [Depth];
    logic             ext_mem    [Depth];
    TagType           tag_mem    [Depth];
    AuxType           aux_mem    [Depth];

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [IdxW-1:0] wr_idx, rd_idx;
    logic [PtrW-1:0] fill;
    logic            empty, full;
    logic            push, pop;

    assign wr_idx = wr_ptr_q[IdxW-1:0];
    assign rd_idx = rd_ptr_q[IdxW-1:0];

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_idx == rd_idx) && (wr_ptr_q[IdxW] != rd_ptr_q[IdxW]);

    // Handshake signals depend only on registered pointers, so a pop in the
    // same cycle never opens room for a push when full.
    assign in_ready_o  = ~full;
    assign out_valid_o = ~empty;
    assign busy_o      = ~empty;

    assign push = in_valid_i & ~full & ~flush_i;
    assign pop  = out_ready_i & ~empty & ~flush_i;

    assign fill    = wr_ptr_q - rd_ptr_q;
    assign count_o = CntW'(fill);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            result_mem[wr_idx] <= result_i;
            status_mem[wr_idx] <= status_i;
            ext_mem[wr_idx]    <= extension_bit_i;
            tag_mem[wr_idx]    <= tag_i;
            aux_mem[wr_idx]    <= aux_i;
        end
    end

    // Data outputs are zeroed while empty so stale entries never leak downstream.
    always_comb begin
        result_o        = '0;
        status_o        = '0;
        extension_bit_o = 1'b0;
        tag_o           = '0;
        aux_o           = '0;
        if (!empty) begin
            result_o        = result_mem[rd_idx];
            status_o        = status_mem[rd_idx];
            extension_bit_o = ext_mem[rd_idx];
            tag_o           = tag_mem[rd_idx];
            aux_o           = aux_mem[rd_idx];
        end
    end

endmodule

// File: tb/tb_fpnew_divsqrt_result_fifo.sv
// tb/tb_fpnew_divsqrt_result_fifo.sv - self-checking bench for fpnew_divsqrt_result_fifo
module tb_fpnew_divsqrt_result_fifo;

    localparam int DEPTH = 4;

    typedef struct packed {
        logic [63:0] r;
        logic [4:0]  s;
        logic        e;
        logic [7:0]  t;
        logic [3:0]  a;
    } entry_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] result_i;
    logic [4:0]  status_i;
    logic        ext_i;
    logic [7:0]  tag_i;
    logic [3:0]  aux_i;
    logic        in_valid;
    logic        in_ready;
    logic        flush;
    logic [63:0] result_o;
    logic [4:0]  status_o;
    logic        ext_o;
    logic [7:0]  tag_o;
    logic [3:0]  aux_o;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  count_o;
    logic        busy_o;

    int errors = 0;
    int checks = 0;

    entry_t model_q[$];
    logic   model_live = 1'b0;
    logic   watch7 = 1'b0;
    logic   seen7 = 1'b0;

    fpnew_divsqrt_result_fifo #(
        .Width  (64),
        .Depth  (DEPTH),
        .TagType(logic [7:0]),
        .AuxType(logic [3:0])
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .result_i       (result_i),
        .status_i       (status_i),
        .extension_bit_i(ext_i),
        .tag_i          (tag_i),
        .aux_i          (aux_i),
        .in_valid_i     (in_valid),
        .in_ready_o     (in_ready),
        .flush_i        (flush),
        .result_o       (result_o),
        .status_o       (status_o),
        .extension_bit_o(ext_o),
        .tag_o          (tag_o),
        .aux_o          (aux_o),
        .out_valid_o    (out_valid),
        .out_ready_i    (out_ready),
        .count_o        (count_o),
        .busy_o         (busy_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue bounded at DEPTH, updated at each edge.
    always @(posedge clk) begin
        bit do_pop, do_push;
        if (!rst_n) begin
            model_q.delete();
            model_live = 1'b1;
        end else if (flush) begin
            model_q.delete();
        end else begin
            do_pop  = out_ready && (model_q.size() > 0);
            do_push = in_valid && (model_q.size() < DEPTH);
            if (do_pop) void'(model_q.pop_front());
            if (do_push) model_q.push_back('{r: result_i, s: status_i, e: ext_i, t: tag_i, a: aux_i});
        end
    end

    // Every-cycle comparison of the DUT outputs against the model.
    always @(negedge clk) begin
        entry_t head;
        if (model_live) begin
            head = (model_q.size() > 0) ? model_q[0] : '0;
            chk("m_out_valid", 64'(out_valid), 64'(model_q.size() > 0));
            chk("m_in_ready", 64'(in_ready), 64'(model_q.size() < DEPTH));
            chk("m_count", 64'(count_o), 64'(model_q.size()));
            chk("m_busy", 64'(busy_o), 64'(model_q.size() > 0));
            chk("m_result", result_o, head.r);
            chk("m_status", 64'(status_o), 64'(head.s));
            chk("m_ext", 64'(ext_o), 64'(head.e));
            chk("m_tag", 64'(tag_o), 64'(head.t));
            chk("m_aux", 64'(aux_o), 64'(head.a));
            if (watch7 && out_valid && tag_o == 8'd7) seen7 = 1'b1;
        end
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic [7:0] t, input logic [63:0] r, input logic [4:0] s);
        in_valid = 1'b1;
        tag_i    = t;
        result_i = r;
        status_i = s;
        ext_i    = t[0];
        aux_i    = t[3:0];
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        result_i = '0; status_i = '0; ext_i = 1'b0; tag_i = '0; aux_i = '0;
        @(negedge clk);
        step();
        rst_n = 1'b1;

        // Reset state
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_count", 64'(count_o), 64'd0);
        chk("rst_result", result_o, 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd0);

        // Fill to full with back-pressure
        for (int n = 1; n <= 4; n++) begin
            drive(8'(n), 64'h3FF0_0000_0000_0000 + 64'(n), 5'(n));
            step();
            chk("fill_count", 64'(count_o), 64'(n));
        end
        chk("full_in_ready", 64'(in_ready), 64'd0);
        drive(8'd5, 64'h3FF0_0000_0000_0005, 5'd5);
        step();
        chk("held_off_count", 64'(count_o), 64'd4);
        chk("held_off_head", 64'(tag_o), 64'd1);
        in_valid = 1'b0;

        // Drain in order
        out_ready = 1'b1;
        for (int n = 1; n <= 4; n++) begin
            chk("drain_valid", 64'(out_valid), 64'd1);
            chk("drain_tag", 64'(tag_o), 64'(n));
            chk("drain_result", result_o, 64'h3FF0_0000_0000_0000 + 64'(n));
            chk("drain_status", 64'(status_o), 64'(n));
            step();
            if (n == 1) chk("drain_in_ready", 64'(in_ready), 64'd1);
        end
        chk("drain_count", 64'(count_o), 64'd0);

        // Streaming: 10 entries through, pointers wrap twice
        for (int i = 0; i <= 10; i++) begin
            if (i > 0) begin
                chk("stream_tag", 64'(tag_o), 64'(i - 1));
                chk("stream_count", 64'(count_o), 64'd1);
            end else begin
                chk("stream_start_count", 64'(count_o), 64'd0);
            end
            if (i < 10) drive(8'(i), 64'(i) * 64'h1111, 5'(i));
            else in_valid = 1'b0;
            step();
        end
        chk("stream_end_count", 64'(count_o), 64'd0);
        out_ready = 1'b0;

        // Flush with concurrent push of tag 7
        watch7 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(8'(10 + i), 64'(100 + i), 5'(i));
            step();
        end
        in_valid = 1'b0;
        chk("pre_flush_count", 64'(count_o), 64'd3);
        drive(8'd7, 64'h7777, 5'd7);
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush_count", 64'(count_o), 64'd0);
        chk("flush_valid", 64'(out_valid), 64'd0);
        out_ready = 1'b1;
        step();
        step();
        chk("flush_tag7_absent", 64'(seen7), 64'd0);
        watch7 = 1'b0;
        out_ready = 1'b0;

        // Reset with 2 entries held
        for (int i = 0; i < 2; i++) begin
            drive(8'(20 + i), 64'(200 + i), 5'(i));
            step();
        end
        in_valid = 1'b0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("mid_rst_count", 64'(count_o), 64'd0);
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_busy", 64'(busy_o), 64'd0);
        drive(8'd5, 64'h5555, 5'd5);
        step();
        in_valid = 1'b0;
        chk("post_rst_valid", 64'(out_valid), 64'd1);
        chk("post_rst_tag", 64'(tag_o), 64'd5);
        chk("post_rst_count", 64'(count_o), 64'd1);
        out_ready = 1'b1;
        step();

        // Randomized traffic checked by the model every cycle
        for (int c = 0; c < 3000; c++) begin
            in_valid  = ($urandom_range(0, 99) < 60);
            out_ready = ($urandom_range(0, 99) < 50);
            flush     = ($urandom_range(0, 63) == 0);
            rst_n     = ($urandom_range(0, 299) != 0);
            result_i  = {$urandom(), $urandom()};
            status_i  = 5'($urandom());
            ext_i     = 1'($urandom());
            tag_i     = 8'($urandom());
            aux_i     = 4'($urandom());
            step();
        end
        rst_n = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 6; c++) step();
        chk("final_count", 64'(count_o), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fpnew_divsqrt_result_fifo.md
Name: fpnew_divsqrt_result_fifo

Overview:
- Small in-order result buffer that sits directly downstream of the multi-cycle div/sqrt opgroup block and feeds the FPU output arbiter.
- Decouples the iterative unit from arbiter back-pressure, so the unit can commit a finished result and start the next operation without parking in its hold state.
- Stores result, status flags, NaN-box extension bit, tag and aux per entry; supports flush and reports busy.

Parameters:
- Width, 64: result width in bits (max FP width of the configured formats).
- Depth, 4: number of entries; power of two, ≥2.
- TagType, logic: operation tag type, carried unchanged.
- AuxType, logic: auxiliary sideband type, carried unchanged.

Ports:
- clk_i  in  1  clock; all state changes on its rising edge.
- rst_ni  in  1  reset, synchronous and active-low.
- result_i  in  Width  result from the div/sqrt stage.
- status_i  in  5 (fpnew_pkg::status_t)  exception flags {NV,DZ,OF,UF,NX}.
- extension_bit_i  in  1  NaN-box extension bit.
- tag_i  in  TagType  operation tag.
- aux_i  in  AuxType  aux sideband.
- in_valid_i  in  1  upstream result valid.
- in_ready_o  out  1  buffer can accept.
- flush_i  in  1  synchronous clear of all contents.
- result_o  out  Width  head entry result.
- status_o  out  5  head entry flags.
- extension_bit_o  out  1  head entry extension bit.
- tag_o  out  TagType  head entry tag.
- aux_o  out  AuxType  head entry aux.
- out_valid_o  out  1  head entry valid.
- out_ready_i  in  1  downstream accepts.
- count_o  out  $clog2(Depth+1)  number of occupied entries.
- busy_o  out  1  any entry held.

Behaviour:
- Storage:
  - Circular array of Depth entries.
  - Read and write pointers are $clog2(Depth)+1 bits; the MSB is the wrap bit.
  - empty: pointers fully equal.
  - full: index bits equal and wrap bits differ.
- Reset (rst_ni=0 at a clock edge):
  - Pointers and count go to 0.
  - out_valid_o=0, in_ready_o=1 from the following cycle.
  - busy_o=0, count_o=0.
  - result_o, status_o, extension_bit_o, tag_o and aux_o read 0.
  - Entry contents are not reset.
- Push: in_valid_i & in_ready_o, with flush_i=0.
  - Writes the entry at the write pointer.
  - Increments the write pointer.
- Pop: out_valid_o & out_ready_i, with flush_i=0.
  - Increments the read pointer.
- in_ready_o = ~full.
  - Registered-state only; no combinational path from out_ready_i.
  - When full, a same-cycle pop does not permit a push.
- out_valid_o = ~empty.
  - Not a fall-through buffer: a pushed entry is visible at the output in the cycle after the push (latency 1).
- Output data:
  - When out_valid_o=1, outputs show the head entry.
  - When out_valid_o=0, all data outputs are forced to 0.
- Simultaneous push and pop when neither empty nor full: both happen; count is unchanged.
- Push into an empty buffer with out_ready_i=1: no pop that cycle (empty); the entry pops at the earliest in the next cycle.
- Pointer wrap: index wraps Depth-1→0 and the wrap bit toggles; order is preserved across the wrap.
- Flush (flush_i=1 at a clock edge):
  - Pointers and count go to 0.
  - A concurrent push is dropped; a concurrent pop is ignored.
  - During the flush cycle, in_ready_o and out_valid_o keep their pre-flush combinational values. Upstream must treat flush as an override.
- count_o = write pointer − read pointer, modulo 2^(ptr width). Range is 0..Depth.
- busy_o = ~empty.
- Reset has priority over flush; flush has priority over push and pop.

Test Plan:
- Reset then idle → in_ready_o=1, out_valid_o=0, count_o=0, result_o=0, busy_o=0.
- Push tags 1,2,3,4 with results 0x3FF0_0000_0000_0000+n, out_ready_i=0:
  - count_o goes 1..4.
  - in_ready_o=0 after the 4th push.
  - A 5th push is held off.
- From full, raise out_ready_i for 4 cycles:
  - Outputs tags 1,2,3,4 in order, each with matching result and status.
  - in_ready_o=1 after the first pop.
  - count_o reaches 0.
- Continuous push and pop for 10 entries (tags 0..9, Depth=4):
  - Pointers wrap twice.
  - Output order is 0..9 with 1-cycle latency.
  - count_o holds at 1 in steady state.
- With 3 entries held, assert flush_i together with in_valid_i and tag 7 → next cycle count_o=0, out_valid_o=0; tag 7 never appears at the output.
- With 2 entries held, assert rst_ni=0 for one edge → next cycle count_o=0, out_valid_o=0, busy_o=0; a subsequent push of tag 5 appears one cycle later.
